sevenseg_mux: RTL and testbench

SEVENSEG_MUX -- requirements
Module: sevenseg_mux

---
 rtl/sevenseg_mux_pkg.sv | 17 +
 rtl/sevenseg_decoder.sv | 11 +
 rtl/sevenseg_mux.sv | 59 +++++
 tb/tb_sevenseg_mux.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/sevenseg_mux_pkg.sv
// Shared constants for the four-digit seven-segment scanner: glyph table,
// blank code, digit count and the all-dark anode value.
package sevenseg_mux_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [3:0] BLANK     = 4'hF;
  localparam logic [7:0] ANODE_OFF = 8'hFF;
  localparam logic [6:0] SEG_OFF   = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns indexed by digit code 0..F.
  localparam logic [6:0] GLYPH_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, SEG_OFF
  };

endpackage

// File: rtl/sevenseg_decoder.sv
// Combinational hex-to-segment lookup, active-low outputs.
module sevenseg_decoder
  import sevenseg_mux_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = GLYPH_TABLE[hex_i];

endmodule

// File: rtl/sevenseg_mux.sv
// Time-multiplexed driver for four digits of an eight-digit display; the upper
// four anodes are kept dark.
module sevenseg_mux
  import sevenseg_mux_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_en,
  input  logic [3:0] d3,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  output logic [7:0] an,
  output logic [6:0] seg
);

  logic [1:0] idx_q, idx_d;
  logic [7:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic [3:0] digit_sel;

  always_comb begin
    digit_sel = d0;
    unique case (idx_q)
      2'd0: digit_sel = d0;
      2'd1: digit_sel = d1;
      2'd2: digit_sel = d2;
      2'd3: digit_sel = d3;
      default: digit_sel = d0;
    endcase
  end

  sevenseg_decoder u_decoder (
    .hex_i (digit_sel),
    .seg_o (seg_d)
  );

  // Outputs reflect the index held before the edge; the index advances alongside.
  always_comb begin
    idx_d = scan_en ? idx_q + 2'd1 : idx_q;
    an_d  = ANODE_OFF & ~(8'd1 << idx_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= 2'd0;
      an_q  <= ANODE_OFF;
      seg_q <= SEG_OFF;
    end else begin
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_sevenseg_mux.sv
// Self-checking bench for sevenseg_mux: directed vector table, countdown and
// glyph sweep sequences, then randomized traffic against a behavioural model.
module tb_sevenseg_mux;

  logic       clk = 1'b0;
  logic       rst;
  logic       scan_en;
  logic [3:0] d3, d2, d1, d0;
  logic [7:0] an;
  logic [6:0] seg;

  int checks   = 0;
  int failures = 0;

  sevenseg_mux dut (
    .clk     (clk),
    .rst     (rst),
    .scan_en (scan_en),
    .d3      (d3),
    .d2      (d2),
    .d1      (d1),
    .d0      (d0),
    .an      (an),
    .seg     (seg)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h7F
  };

  typedef struct {
    string       name;
    logic        rst;
    logic        en;
    logic [15:0] digs;  // {d3,d2,d1,d0}
    logic [7:0]  an;
    logic [6:0]  seg;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string n, input logic r, input logic e,
                              input logic [15:0] dg, input logic [7:0] a,
                              input logic [6:0] s);
    vec_t v;
    v.name = n; v.rst = r; v.en = e; v.digs = dg; v.an = a; v.seg = s;
    vecs.push_back(v);
  endfunction

  task automatic apply(input logic r, input logic e, input logic [15:0] dg);
    rst = r; scan_en = e;
    {d3, d2, d1, d0} = dg;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] exp_an, input logic [6:0] exp_seg);
    checks++;
    if (an !== exp_an || seg !== exp_seg) begin
      failures++;
      $display("FAIL %s: got an=%h seg=%h, expected an=%h seg=%h",
               name, an, seg, exp_an, exp_seg);
    end
  endtask

  task automatic do_reset();
    apply(1'b1, 1'b0, 16'h0000);
    tick();
    tick();
  endtask

  initial begin
    logic [6:0] countdown [10];
    int         m_idx;
    int         dv [4];
    logic       r, e;
    logic [7:0] exp_an;
    logic [6:0] exp_seg;

    apply(1'b1, 1'b1, 16'h0000);

    // Reset for 5 cycles with scan_en high (must be ignored), then rotation.
    for (int i = 0; i < 5; i++) add("reset", 1'b1, 1'b1, 16'h0000, 8'hFF, 7'h7F);
    add("rot0", 1'b0, 1'b1, 16'hFF10, 8'hFE, 7'h40);
    add("rot1", 1'b0, 1'b1, 16'hFF10, 8'hFD, 7'h79);
    add("rot2", 1'b0, 1'b1, 16'hFF10, 8'hFB, 7'h7F);
    add("rot3", 1'b0, 1'b1, 16'hFF10, 8'hF7, 7'h7F);
    add("rot4", 1'b0, 1'b1, 16'hFF10, 8'hFE, 7'h40);
    // idx is now 1: hold for 10 cycles, pulse once, then show digit 2.
    for (int i = 0; i < 10; i++) add("hold", 1'b0, 1'b0, 16'hFF10, 8'hFD, 7'h79);
    add("pulse", 1'b0, 1'b1, 16'hFF10, 8'hFD, 7'h79);
    add("after_pulse", 1'b0, 1'b0, 16'hFF10, 8'hFB, 7'h7F);
    // Mid-scan reset while an=FB, then restart at digit 0.
    add("midrst", 1'b1, 1'b1, 16'hFF10, 8'hFF, 7'h7F);
    add("restart0", 1'b0, 1'b1, 16'hFF10, 8'hFE, 7'h40);
    add("restart1", 1'b0, 1'b1, 16'hFF10, 8'hFD, 7'h79);

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].en, vecs[i].digs);
      tick();
      check(vecs[i].name, vecs[i].an, vecs[i].seg);
    end

    // Countdown: d0 stepped 9..0 every 8 scanning cycles; digit-0 slots are j=0,4.
    countdown = '{7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
    do_reset();
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < 8; j++) begin
        apply(1'b0, 1'b1, {4'h3, 4'h2, 4'h0, 4'(9 - k)});
        tick();
        if (j == 0 || j == 4) check("countdown", 8'hFE, countdown[k]);
      end
    end

    // Full glyph sweep on digit 0, one scan round per code.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 4; j++) begin
        apply(1'b0, 1'b1, {4'h8, 4'h8, 4'h8, 4'(k)});
        tick();
        if (j == 0) check("sweep", 8'hFE, GLYPH[k]);
      end
    end

    // Randomized traffic against a position/glyph model.
    do_reset();
    m_idx = 0;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 19) == 0);
      e = 1'($urandom_range(0, 1));
      for (int k = 0; k < 4; k++) dv[k] = int'($urandom_range(0, 15));
      apply(r, e, {4'(dv[3]), 4'(dv[2]), 4'(dv[1]), 4'(dv[0])});
      if (r) begin
        exp_an  = 8'hFF;
        exp_seg = 7'h7F;
        m_idx   = 0;
      end else begin
        exp_an  = 8'hFF - 8'(1 << m_idx);
        exp_seg = GLYPH[dv[m_idx]];
        if (e) m_idx = (m_idx + 1) % 4;
      end
      tick();
      check("random", exp_an, exp_seg);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
